// File: rtl/digit_accum_reg.sv
// Multi-digit entry register: MS-digit-first shift-in with count, full/overflow and commit/hold.
// Optional backspace support is enabled by defining DIGIT_ACC_BACKSPACE_EN.
module digit_accum_reg #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 4,
  localparam int NUM_W     = DIGIT_W * MAX_DIGITS,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               digit_valid,
  output logic               digit_ready,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               backspace,
  input  logic               commit,
  output logic [NUM_W-1:0]   number_out,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic               full,
  output logic               overflow,
  output logic [NUM_W-1:0]   value_out,
  output logic               value_valid
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    HELD  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_W-1:0]   number_reg, number_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_W-1:0]   value_reg, value_next;
  logic               overflow_reg, overflow_next;
  logic               valid_reg, valid_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= EMPTY;
      number_reg   <= '0;
      cnt_reg      <= '0;
      value_reg    <= '0;
      overflow_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      number_reg   <= number_next;
      cnt_reg      <= cnt_next;
      value_reg    <= value_next;
      overflow_reg <= overflow_next;
      valid_reg    <= valid_next;
    end
  end

  // Event priority: clear > commit > backspace > digit; losers are simply dropped.
  always_comb begin
    state_next    = state_reg;
    number_next   = number_reg;
    cnt_next      = cnt_reg;
    value_next    = value_reg;
    overflow_next = 1'b0;
    valid_next    = 1'b0;
    if (clear) begin
      number_next = '0;
      cnt_next    = '0;
      state_next  = EMPTY;
    end else if (commit) begin
      value_next = number_reg;
      valid_next = 1'b1;
      state_next = HELD;
    end
`ifdef DIGIT_ACC_BACKSPACE_EN
    else if (backspace) begin
      if (state_reg == ENTRY || state_reg == FULL) begin
        number_next = number_reg >> DIGIT_W;
        cnt_next    = cnt_reg - CNT_W'(1);
        state_next  = (cnt_next == '0) ? EMPTY : ENTRY;
      end
    end
`endif
    else if (digit_valid) begin
      if (state_reg == FULL) begin
        overflow_next = 1'b1;
      end else begin
        if (state_reg == HELD) begin
          number_next = NUM_W'(digit_in);
          cnt_next    = CNT_W'(1);
        end else begin
          number_next = (number_reg << DIGIT_W) | NUM_W'(digit_in);
          cnt_next    = cnt_reg + CNT_W'(1);
        end
        state_next = (cnt_next == CNT_W'(MAX_DIGITS)) ? FULL : ENTRY;
      end
    end
  end

`ifndef DIGIT_ACC_BACKSPACE_EN
  logic unused_backspace;
  assign unused_backspace = backspace;
`endif

  assign digit_ready = (state_reg != FULL);
  assign full        = (state_reg == FULL);
  assign number_out  = number_reg;
  assign digit_cnt   = cnt_reg;
  assign value_out   = value_reg;
  assign overflow    = overflow_reg;
  assign value_valid = valid_reg;

endmodule
